// File: rtl/dmem_ctrl_pkg.sv
// Shared encodings for the data-memory access controller: request sizes,
// FSM states and byte-lane write masks.
package dmem_ctrl_pkg;

   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;
   localparam logic [1:0] SIZE_X = 2'b11;

   localparam logic [3:0] MASK_B = 4'b0001;
   localparam logic [3:0] MASK_H = 4'b0011;
   localparam logic [3:0] MASK_W = 4'b1111;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RMW_WR,
      RESP
   } state_t;

   // Right-aligned lane mask for a request size (illegal size yields no lanes).
   function automatic logic [3:0] size_mask(input logic [1:0] size);
      case (size)
         SIZE_B:  size_mask = MASK_B;
         SIZE_H:  size_mask = MASK_H;
         SIZE_W:  size_mask = MASK_W;
         default: size_mask = 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Byte-lane datapath: load lane extraction with sign extension, store merge
// into a read word, and alignment/size error decode.
module dmem_lane_unit
   import dmem_ctrl_pkg::*;
(
   input  logic [1:0]  offset,
   input  logic [1:0]  size,
   input  logic        is_signed,
   input  logic [31:0] rdata,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merged_data,
   output logic        align_err
);

   logic [4:0]  shamt;
   logic [31:0] rshift;
   logic [31:0] wshift;
   logic [3:0]  lane_mask;

   assign shamt     = {offset, 3'b000};
   assign rshift    = rdata >> shamt;
   assign wshift    = wdata << shamt;
   assign lane_mask = size_mask(size) << offset;

   assign align_err = (size == SIZE_X)
                    | ((size == SIZE_H) & (offset == 2'd3))
                    | ((size == SIZE_W) & (offset != 2'd0));

   always_comb begin
      load_data = rshift;
      case (size)
         SIZE_B:  load_data = {{24{is_signed & rshift[7]}}, rshift[7:0]};
         SIZE_H:  load_data = {{16{is_signed & rshift[15]}}, rshift[15:0]};
         default: load_data = rshift;
      endcase
   end

   // Store bytes replace only their own lanes; the rest keep the read data.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_merge
         assign merged_data[8*gi +: 8] = lane_mask[gi] ? wshift[8*gi +: 8]
                                                       : rdata[8*gi +: 8];
      end
   endgenerate

endmodule

// File: rtl/dmem_ctrl.sv
// Two-master access controller for the data memory: round-robin arbitration,
// request validation, direct or read-modify-write stores and lane-extracted loads.
module dmem_ctrl
   import dmem_ctrl_pkg::*;
#(
   parameter int ADDR_W = 12
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_req_valid,
   output logic        m0_req_ready,
   input  logic        m0_req_we,
   input  logic [31:0] m0_req_addr,
   input  logic [1:0]  m0_req_size,
   input  logic        m0_req_signed,
   input  logic [31:0] m0_req_wdata,
   output logic        m0_rsp_valid,
   input  logic        m1_req_valid,
   output logic        m1_req_ready,
   input  logic        m1_req_we,
   input  logic [31:0] m1_req_addr,
   input  logic [1:0]  m1_req_size,
   input  logic        m1_req_signed,
   input  logic [31:0] m1_req_wdata,
   output logic        m1_rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        mem_ce,
   output logic        mem_we,
   output logic        mem_memRr,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wtData,
   output logic [3:0]  mem_w_mask,
   output logic [3:0]  mem_r_mask,
   input  logic [31:0] mem_rdData
);

   state_t      state_reg, state_next;
   logic        last_grant_reg;
   logic        master_reg;
   logic        we_reg;
   logic [31:0] addr_reg;
   logic [1:0]  size_reg;
   logic        signed_reg;
   logic [31:0] wdata_reg;
   logic        err_reg;
   logic [31:0] rdata_reg;
   logic [31:0] merged_reg;

   logic        grant0, grant1, accept, sel_m1;
   logic        sel_we, sel_signed, range_err;
   logic [31:0] sel_addr, sel_wdata;
   logic [1:0]  sel_size;
   logic [1:0]  lane_offset, lane_size;
   logic [31:0] load_data, merged_data;
   logic        align_err, direct_store;

   // With both masters requesting, the one not granted last wins.
   assign grant0       = m0_req_valid & (~m1_req_valid | last_grant_reg);
   assign grant1       = m1_req_valid & (~m0_req_valid | ~last_grant_reg);
   assign m0_req_ready = (state_reg == IDLE) & ~rst & grant0;
   assign m1_req_ready = (state_reg == IDLE) & ~rst & grant1;
   assign accept       = m0_req_ready | m1_req_ready;
   assign sel_m1       = m1_req_ready;

   assign sel_we     = sel_m1 ? m1_req_we     : m0_req_we;
   assign sel_addr   = sel_m1 ? m1_req_addr   : m0_req_addr;
   assign sel_size   = sel_m1 ? m1_req_size   : m0_req_size;
   assign sel_signed = sel_m1 ? m1_req_signed : m0_req_signed;
   assign sel_wdata  = sel_m1 ? m1_req_wdata  : m0_req_wdata;
   assign range_err  = |sel_addr[31:ADDR_W];

   // The lane unit decodes the incoming request in IDLE and the held one afterwards.
   assign lane_offset  = (state_reg == IDLE) ? sel_addr[1:0] : addr_reg[1:0];
   assign lane_size    = (state_reg == IDLE) ? sel_size      : size_reg;
   assign direct_store = (size_reg == SIZE_W) | (addr_reg[1:0] == 2'd0);

   dmem_lane_unit u_lane (
      .offset      (lane_offset),
      .size        (lane_size),
      .is_signed   (signed_reg),
      .rdata       (mem_rdData),
      .wdata       (wdata_reg),
      .load_data   (load_data),
      .merged_data (merged_data),
      .align_err   (align_err)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         last_grant_reg <= 1'b1;
         master_reg     <= 1'b0;
         we_reg         <= 1'b0;
         addr_reg       <= '0;
         size_reg       <= SIZE_B;
         signed_reg     <= 1'b0;
         wdata_reg      <= '0;
         err_reg        <= 1'b0;
         rdata_reg      <= '0;
         merged_reg     <= '0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            master_reg     <= sel_m1;
            last_grant_reg <= sel_m1;
            we_reg         <= sel_we;
            addr_reg       <= sel_addr;
            size_reg       <= sel_size;
            signed_reg     <= sel_signed;
            wdata_reg      <= sel_wdata;
            err_reg        <= align_err | range_err;
            rdata_reg      <= '0;
         end
         if ((state_reg == ACCESS) && !err_reg) begin
            if (!we_reg) begin
               rdata_reg <= load_data;
            end else if (!direct_store) begin
               merged_reg <= merged_data;
            end
         end
      end
   end

   always_comb begin
      state_next   = state_reg;
      m0_rsp_valid = 1'b0;
      m1_rsp_valid = 1'b0;
      rsp_rdata    = '0;
      rsp_err      = 1'b0;
      mem_ce       = 1'b0;
      mem_we       = 1'b0;
      mem_memRr    = 1'b0;
      mem_addr     = '0;
      mem_wtData   = '0;
      mem_w_mask   = 4'b0000;
      mem_r_mask   = 4'b0000;
      case (state_reg)
         IDLE: begin
            if (accept) state_next = ACCESS;
         end
         ACCESS: begin
            // A rejected request idles here with every enable low so that all
            // non-RMW responses share the same two-cycle latency.
            state_next = RESP;
            if (!err_reg) begin
               mem_ce   = 1'b1;
               mem_addr = {addr_reg[31:2], 2'b00};
               if (!we_reg) begin
                  mem_memRr  = 1'b1;
                  mem_r_mask = MASK_W;
               end else if (direct_store) begin
                  mem_we     = 1'b1;
                  mem_w_mask = size_mask(size_reg);
                  mem_wtData = wdata_reg;
               end else begin
                  mem_memRr  = 1'b1;
                  mem_r_mask = MASK_W;
                  state_next = RMW_WR;
               end
            end
         end
         RMW_WR: begin
            mem_ce     = 1'b1;
            mem_we     = 1'b1;
            mem_addr   = {addr_reg[31:2], 2'b00};
            mem_w_mask = MASK_W;
            mem_wtData = merged_reg;
            state_next = RESP;
         end
         RESP: begin
            m0_rsp_valid = ~master_reg;
            m1_rsp_valid = master_reg;
            rsp_rdata    = rdata_reg;
            rsp_err      = err_reg;
            state_next   = IDLE;
         end
         default: state_next = IDLE;
      endcase
      // Reset wins in any state: nothing reaches the memory or the masters.
      if (rst) begin
         state_next   = IDLE;
         m0_rsp_valid = 1'b0;
         m1_rsp_valid = 1'b0;
         rsp_rdata    = '0;
         rsp_err      = 1'b0;
         mem_ce       = 1'b0;
         mem_we       = 1'b0;
         mem_memRr    = 1'b0;
         mem_addr     = '0;
         mem_wtData   = '0;
         mem_w_mask   = 4'b0000;
         mem_r_mask   = 4'b0000;
      end
   end

endmodule
